// File: rtl/seq_match_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_match_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;
    localparam int LEN_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        DONE
    } state_t;

    // Low 'len' bits set; callers truncate to their pattern width.
    function automatic logic [15:0] mask_len(input logic [LEN_W-1:0] len);
        return 16'((17'd1 << len) - 17'd1);
    endfunction

endpackage

// File: rtl/seq_match_ctrl_if.sv
// Config, control, serial-input and status signals of the pattern detector.
interface seq_match_ctrl_if
    import seq_match_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) ();

    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_limit;
    logic               start;
    logic               abort;
    logic               in_valid;
    logic               in_bit;
    logic               busy;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               done;
    logic               cfg_err;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
        output start, abort, in_valid, in_bit,
        input  busy, match, match_cnt, done, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
        input  start, abort, in_valid, in_bit,
        output busy, match, match_cnt, done, cfg_err
    );

endinterface

// File: rtl/seq_match_window.sv
// Bit history, fill counter and masked comparator; hit is combinational on the shifting bit.
module seq_match_window
    import seq_match_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift,
    input  logic               clear,
    input  logic               restart_fill,
    input  logic               data_bit,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_new;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_q;
    logic               full;

    assign hist_new = (hist_q << 1) | MAX_LEN'(data_bit);
    assign mask     = MAX_LEN'(mask_len(len));
    assign full     = ({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len};
    assign hit      = shift && full && (((hist_new ^ pattern) & mask) == '0);

    // Non-overlap mode restarts the fill so the next hit needs len fresh bits.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift) begin
            hist_q <= hist_new;
            if (hit && restart_fill) begin
                fill_q <= '0;
            end else if (fill_q < len) begin
                fill_q <= fill_q + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Arms, sequences and counts matches of a runtime-programmable serial pattern detector.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input logic             clk,
    input logic             rst,
    seq_match_ctrl_if.slave bus
);

    state_t             state_q;
    state_t             state_d;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   limit_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               match_q;
    logic               cfg_err_q;
    logic               cfg_err_d;
    logic               cfg_load;
    logic               legal;
    logic               shift;
    logic               clear;
    logic               hit;

    assign legal   = (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));
    assign shift   = (state_q == HUNT) && bus.in_valid && !bus.abort;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    seq_match_window #(
        .MAX_LEN (MAX_LEN)
    ) u_window (
        .clk          (clk),
        .rst          (rst),
        .shift        (shift),
        .clear        (clear),
        .restart_fill (!overlap_q),
        .data_bit     (bus.in_bit),
        .pattern      (pattern_q),
        .len          (len_q),
        .hit          (hit)
    );

    // Start always judges the config already held, so a same-cycle write only affects later starts.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cfg_err_d = 1'b0;
        cfg_load  = 1'b0;
        clear     = 1'b0;
        case (state_q)
            HUNT: begin
                cfg_err_d = bus.cfg_we;
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (hit) begin
                    cnt_d = cnt_inc;
                    if ((limit_q != '0) && (cnt_inc == limit_q)) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                cfg_load = bus.cfg_we;
                if (bus.start && !bus.abort) begin
                    if (legal) begin
                        state_d = HUNT;
                        cnt_d   = '0;
                        clear   = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            limit_q   <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            match_q   <= hit;
            cfg_err_q <= cfg_err_d;
            if (cfg_load) begin
                pattern_q <= bus.cfg_pattern;
                len_q     <= bus.cfg_len;
                overlap_q <= bus.cfg_overlap;
                limit_q   <= bus.cfg_limit;
            end
        end
    end

    assign bus.busy      = (state_q == HUNT);
    assign bus.done      = (state_q == DONE);
    assign bus.match     = match_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: doc/seq_match_ctrl.md
Name: seq_match_ctrl

Overview:
Controller that configures, arms and sequences a programmable serial-bit pattern detector, for example 10001 or 11011. It holds a runtime pattern and length, and selects overlapping or non-overlapping detection. It counts matches against a programmable limit, then stops. It sits between a register/config interface and a serial bit source, replacing hard-coded detector FSMs.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (legal cfg_len is 1..MAX_LEN)
CNT_W, 8, width of match counter and limit

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
cfg_we  input  1  write cfg_pattern/cfg_len/cfg_overlap/cfg_limit into shadow registers
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is first bit received, bit [0] is last
cfg_len  input  4  pattern length
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_limit  input  CNT_W  stop after this many matches; 0 = unlimited
start  input  1  arm detector (pulse)
abort  input  1  disarm detector (pulse)
in_valid  input  1  in_bit is valid this cycle
in_bit  input  1  serial data bit
busy  output  1  high in HUNT state
match  output  1  one-cycle pulse per detected pattern
match_cnt  output  CNT_W  matches since last accepted start, saturating
done  output  1  level, high in DONE state
cfg_err  output  1  one-cycle pulse on rejected config write or start

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: state=IDLE; busy, match, done, cfg_err = 0; match_cnt = 0.
  - Config: pattern=0, len=0 (illegal), overlap=0, limit=0; history and fill cleared.
- States: IDLE, HUNT, DONE.
- Config writes:
  - Accepted only in IDLE or DONE; registers update at the next edge.
  - cfg_we in HUNT is ignored and pulses cfg_err the next cycle.
- start in IDLE/DONE:
  - Legal config (1 <= len <= MAX_LEN): next state HUNT; match_cnt, history and fill cleared; done drops.
  - Illegal config: state unchanged and cfg_err pulses.
  - start in HUNT is ignored.
- cfg_we and start in the same cycle: start evaluates the old config.
- abort:
  - In HUNT: next state IDLE; match_cnt is held and no match is issued that cycle.
  - abort and start together: abort wins.
  - In IDLE/DONE: no effect.
- In HUNT, for each in_valid cycle:
  - hist = {hist[MAX_LEN-2:0], in_bit}.
  - fill increments, saturating at len.
  - Hit condition: (fill+1 >= len) and hist_new[len-1:0] == pattern[len-1:0].
- On a hit:
  - At the next edge: match=1 for exactly one cycle; match_cnt increments, saturating at all-ones.
  - Latency: match is high in the cycle after the completing bit.
  - Non-overlap: fill resets to 0, so the next match needs len fresh bits.
  - Overlap: fill is unchanged.
- in_valid=0: nothing shifts. in_valid outside HUNT is ignored.
- Limit:
  - If limit != 0 and the incremented count equals limit: state goes to DONE on the same edge that asserts match.
  - DONE: done=1, busy=0; count holds until the next start.
- Pattern compare uses only the low len bits; upper history bits are don't-care.

Decomposition:
- Package seq_match_pkg:
  - state enum (IDLE, HUNT, DONE)
  - MAX_LEN default
  - function mask_len(len) returning a len-bit LSB mask
- Sub-module seq_match_window: shift history, fill counter and masked comparator.
  - Inputs: shift, clear, restart_fill, bit, pattern, len.
  - Output: hit (combinational).
  - The top level holds the FSM, config shadow registers, counter and limit logic.

Test Plan:
- Non-overlap: cfg 10001/len 5/overlap 0/limit 0, start, stream 1,0,0,0,1,0,0,0,1 -> one match pulse, one cycle after bit 5; match_cnt=1.
- Overlap: same stream with overlap=1 -> matches one cycle after bits 5 and 9; match_cnt=2.
- Limit: pattern 11011/len 5/limit 2/overlap 1, stream 11011011011 -> matches after bits 5 and 8; DONE entered with the second match; busy=0, done=1; bit 11 ignored, count stays 2.
- Illegal config: len=0 or len=9, start -> cfg_err pulse, state IDLE, busy=0; cfg_we during HUNT -> cfg_err pulse, pattern unchanged.
- Abort and gaps: in_valid gaps mid-pattern do not break the match; abort+start in the same cycle -> IDLE, match_cnt held.
- Reset mid-HUNT with 4 of 5 bits received -> all outputs 0; after reconfig and start, the 5th bit alone does not match.
